// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a shared memory port (instruction vs data).
// Grants are registered, with a bounded wait for mem_ready and an err pulse on timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       mem_ready,
  output logic       gnt_i,
  output logic       gnt_d,
  output logic       sel,
  output logic       mem_valid,
  output logic       err,
  output logic [1:0] dbg_state
);

  // Handshake: a requester raises req_x and holds it until mem_ready is seen
  // while it owns the port (gnt_x high); dropping req_x earlier aborts the access.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic       last_gnt;
  logic       last_gnt_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] cnt_inc;
  logic       err_nxt;
  logic       enter_grant;
  logic       owner;
  logic       own_req;
  logic       oth_req;

  assign cnt_inc   = wait_cnt + 4'd1;
  assign owner     = (state == GRANT_D);
  assign own_req   = owner ? req_d : req_i;
  assign oth_req   = owner ? req_i : req_d;
  assign dbg_state = state;

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    err_nxt      = 1'b0;
    enter_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && req_d)
          state_nxt = last_gnt ? GRANT_I : GRANT_D;
        else if (req_i)
          state_nxt = GRANT_I;
        else if (req_d)
          state_nxt = GRANT_D;
        enter_grant = (state_nxt != IDLE);
      end
      GRANT_I, GRANT_D: begin
        // Completion wins over both abort and timeout in the same cycle.
        if (mem_ready) begin
          last_gnt_nxt = owner;
          if (oth_req) begin
            state_nxt   = owner ? GRANT_I : GRANT_D;
            enter_grant = 1'b1;
          end else if (own_req) begin
            state_nxt   = state;
            enter_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!own_req) begin
          state_nxt    = IDLE;
          last_gnt_nxt = owner;
        end else if (cnt_inc == TIMEOUT_L) begin
          state_nxt    = IDLE;
          last_gnt_nxt = owner;
          err_nxt      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      wait_cnt  <= 4'd0;
      gnt_i     <= 1'b0;
      gnt_d     <= 1'b0;
      sel       <= 1'b0;
      mem_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      err      <= err_nxt;
      if (enter_grant)
        wait_cnt <= 4'd0;
      else if (state != IDLE && !mem_ready)
        wait_cnt <= cnt_inc;
      gnt_i     <= (state_nxt == GRANT_I);
      gnt_d     <= (state_nxt == GRANT_D);
      mem_valid <= (state_nxt != IDLE);
      // sel keeps pointing at the last owner while the port is idle.
      if (state_nxt == GRANT_I)
        sel <= 1'b0;
      else if (state_nxt == GRANT_D)
        sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, round-robin, back-to-back,
// timeout, abort and mid-grant reset, with an invariant check every cycle.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_i;
  logic       req_d;
  logic       mem_ready;
  logic       gnt_i;
  logic       gnt_d;
  logic       sel;
  logic       mem_valid;
  logic       err;
  logic [1:0] dbg_state;
  logic [4:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .req_d     (req_d),
    .mem_ready (mem_ready),
    .gnt_i     (gnt_i),
    .gnt_d     (gnt_d),
    .sel       (sel),
    .mem_valid (mem_valid),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Output vector: {gnt_i, gnt_d, sel, mem_valid, err}
  assign outs = {gnt_i, gnt_d, sel, mem_valid, err};

  // Advance one clock; sample 1ns after the edge and check the invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      checks++;
      if ((gnt_i & gnt_d) !== 1'b0) begin
        errors++;
        $display("FAIL mutex gnt_i=%b gnt_d=%b required not both 1", gnt_i, gnt_d);
      end
      checks++;
      if (mem_valid !== (gnt_i | gnt_d)) begin
        errors++;
        $display("FAIL valid_consistency mem_valid=%b required %b", mem_valid, gnt_i | gnt_d);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 1'b0; req_d = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL reset_outs got %b required 00000", outs);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d required 0", dbg_state);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL idle_after_reset got %b required 00000", outs);
    end
  endtask

  task automatic test_first_grant();
    req_i = 1'b1; req_d = 1'b1; mem_ready = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b10010) begin
      errors++; $display("FAIL first_grant_i got %b required 10010", outs);
    end
  endtask

  task automatic test_alternate();
    logic [4:0] exp_seq [4];
    exp_seq[0] = 5'b01110; exp_seq[1] = 5'b10010;
    exp_seq[2] = 5'b01110; exp_seq[3] = 5'b10010;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (outs !== exp_seq[k]) begin
        errors++; $display("FAIL alternate_%0d got %b required %b", k, outs, exp_seq[k]);
      end
    end
    // Owner (I) drops its request without completion: abort to idle, no err.
    mem_ready = 1'b0; req_i = 1'b0; req_d = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL abort_no_pending got %b required 00000", outs);
    end
  endtask

  task automatic test_back_to_back();
    req_i = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b10010) begin
      errors++; $display("FAIL b2b_enter got %b required 10010", outs);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b10010) begin
      errors++; $display("FAIL b2b_regrant got %b required 10010", outs);
    end
    req_i = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL complete_to_idle got %b required 00000", outs);
    end
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL idle_ignores_ready got %b required 00000", outs);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    req_d = 1'b1;
    tick();
    for (int k = 0; k < 20 && gnt_d === 1'b1; k++) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 15) begin
      errors++; $display("FAIL timeout_len got %0d cycles required 15", n);
    end
    checks++;
    if (outs !== 5'b00101) begin
      errors++; $display("FAIL timeout_err got %b required 00101", outs);
    end
    req_d = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b00100) begin
      errors++; $display("FAIL err_one_cycle got %b required 00100", outs);
    end
  endtask

  task automatic test_ready_at_timeout();
    req_d = 1'b1;
    tick();
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if (outs !== 5'b01110) begin
      errors++; $display("FAIL last_wait_cycle got %b required 01110", outs);
    end
    mem_ready = 1'b1; req_d = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b00100) begin
      errors++; $display("FAIL ready_beats_timeout got %b required 00100", outs);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_abort();
    req_i = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b10010) begin
      errors++; $display("FAIL abort_enter got %b required 10010", outs);
    end
    req_i = 1'b0; req_d = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL abort_idle got %b required 00000", outs);
    end
    tick();
    checks++;
    if (outs !== 5'b01110) begin
      errors++; $display("FAIL abort_pending_d got %b required 01110", outs);
    end
  endtask

  task automatic test_reset_mid_grant();
    req_i = 1'b1;
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== 5'b00000) begin
      errors++; $display("FAIL reset_mid_outs got %b required 00000", outs);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_mid_state got %0d required 0", dbg_state);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b10010) begin
      errors++; $display("FAIL post_reset_i_first got %b required 10010", outs);
    end
    req_i = 1'b0; req_d = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_alternate();
    test_back_to_back();
    test_timeout();
    test_ready_at_timeout();
    test_abort();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
